bcd_scan_disp: RTL and testbench

BCD_SCAN_DISP -- requirements
Module: bcd_scan_disp

---
 rtl/bcd_scan_disp.sv | 220 ++++++++++++++++++++++
 tb/tb_bcd_scan_disp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_disp.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_scan_disp
//  Description : Sequential binary-to-BCD converter (double dabble, one
//                iteration per clock) for a mod-120 count, followed by a
//                3-digit multiplexed active-low 7-segment scanner with
//                leading-zero blanking and a terminal-count decimal point.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_scan_disp #(
    parameter int SCAN_DIV = 4
) (
    input  logic        Clk,
    input  logic        MR,
    input  logic [7:0]  Bin,
    input  logic        TCin,
    output logic [11:0] Bcd,
    output logic        Valid,
    output logic        Err,
    output logic [6:0]  Seg,
    output logic [2:0]  An,
    output logic        Dp
);

    localparam int c_PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_capture;
    logic          r_force;
    logic [2:0]    r_iter;
    logic [7:0]    r_last;
    // {hundreds, tens, units, binary} working register
    logic [19:0]   r_shift;
    logic [19:0]   w_adj;
    logic [19:0]   w_dd;
    logic [11:0]   r_bcd;
    logic          r_valid;
    logic          r_err;

    // ------------------------------------------------------------------------
    // Scanner state
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_pre;
    logic [1:0]         r_idx;
    logic               r_tc;
    logic [6:0]         r_seg;
    logic [2:0]         r_an;
    logic               r_dp;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [6:0]         w_seg;
    logic [2:0]         w_an;

    // State register for the converter FSM
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a capture happens on a new value or after reset
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((Bin != r_last) || r_force) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_CONV;
                end
            end
            ST_CONV: begin
                if (r_iter == 3'd7) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One double-dabble step: add 3 to BCD nibbles >= 5, then shift left
    always_comb begin
        w_adj          = r_shift;
        w_adj[11:8]    = (r_shift[11:8]  >= 4'd5) ? r_shift[11:8]  + 4'd3 : r_shift[11:8];
        w_adj[15:12]   = (r_shift[15:12] >= 4'd5) ? r_shift[15:12] + 4'd3 : r_shift[15:12];
        w_adj[19:16]   = (r_shift[19:16] >= 4'd5) ? r_shift[19:16] + 4'd3 : r_shift[19:16];
        w_dd           = w_adj << 1;
    end

    // Converter datapath: capture, iterate, then publish result with a pulse
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            r_force <= 1'b1;
            r_iter  <= 3'd0;
            r_last  <= 8'd0;
            r_shift <= 20'd0;
            r_bcd   <= 12'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_shift <= {12'd0, Bin};
                        r_last  <= Bin;
                        r_force <= 1'b0;
                        r_iter  <= 3'd0;
                    end
                end
                ST_CONV: begin
                    r_shift <= w_dd;
                    r_iter  <= r_iter + 3'd1;
                end
                ST_DONE: begin
                    r_bcd   <= r_shift[19:8];
                    r_err   <= (r_last > 8'd119);
                    r_valid <= 1'b1;
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Digit select, blanking and segment decode for the current index
    always_comb begin
        w_nib   = r_bcd[3:0];
        w_blank = 1'b0;
        w_an    = 3'b111;
        case (r_idx)
            2'd0: begin
                w_nib = r_bcd[3:0];
                w_an  = 3'b110;
            end
            2'd1: begin
                w_nib   = r_bcd[7:4];
                w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
                w_an    = 3'b101;
            end
            2'd2: begin
                w_nib   = r_bcd[11:8];
                w_blank = (r_bcd[11:8] == 4'd0);
                w_an    = 3'b011;
            end
            default: begin
                w_blank = 1'b1;
            end
        endcase

        case (w_nib)
            4'd0:    w_seg = 7'b1000000;
            4'd1:    w_seg = 7'b1111001;
            4'd2:    w_seg = 7'b0100100;
            4'd3:    w_seg = 7'b0110000;
            4'd4:    w_seg = 7'b0011001;
            4'd5:    w_seg = 7'b0010010;
            4'd6:    w_seg = 7'b0000010;
            4'd7:    w_seg = 7'b1111000;
            4'd8:    w_seg = 7'b0000000;
            4'd9:    w_seg = 7'b0010000;
            default: w_seg = c_SEG_BLANK;
        endcase
        if (w_blank) begin
            w_seg = c_SEG_BLANK;
        end
    end

    // Scanner: prescaler, digit index and registered display drive
    always_ff @(posedge Clk or negedge MR) begin
        if (!MR) begin
            r_pre <= '0;
            r_idx <= 2'd0;
            r_tc  <= 1'b0;
            r_seg <= c_SEG_BLANK;
            r_an  <= 3'b111;
            r_dp  <= 1'b1;
        end else begin
            r_tc  <= TCin;
            r_seg <= w_seg;
            r_an  <= w_an;
            r_dp  <= !((r_idx == 2'd0) && r_tc);
            if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + c_PRE_W'(1);
            end
        end
    end

    assign Bcd   = r_bcd;
    assign Valid = r_valid;
    assign Err   = r_err;
    assign Seg   = r_seg;
    assign An    = r_an;
    assign Dp    = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_bcd_scan_disp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_scan_disp
//  Description : Directed self-checking bench for bcd_scan_disp. Expected
//                conversion results are queued when Bin is driven and checked
//                whenever Valid pulses; display, latency and reset behaviour
//                are checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_scan_disp;

    logic        Clk = 1'b0;
    logic        MR  = 1'b1;
    logic [7:0]  Bin = 8'd0;
    logic        TCin = 1'b0;
    logic [11:0] Bcd;
    logic        Valid;
    logic        Err;
    logic [6:0]  Seg;
    logic [2:0]  An;
    logic        Dp;

    int n_vec = 0;
    int n_err = 0;
    int valid_cnt = 0;
    logic [12:0] q[$];

    bcd_scan_disp #(.SCAN_DIV(4)) dut (
        .Clk   (Clk),
        .MR    (MR),
        .Bin   (Bin),
        .TCin  (TCin),
        .Bcd   (Bcd),
        .Valid (Valid),
        .Err   (Err),
        .Seg   (Seg),
        .An    (An),
        .Dp    (Dp)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Scoreboard: every Valid pulse must match the oldest queued result
    always @(negedge Clk) begin
        if (Valid === 1'b1) begin
            logic [12:0] e;
            valid_cnt++;
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("bcd", 32'(Bcd), 32'(e[12:1]));
                chk("err", 32'(Err), 32'(e[0]));
            end
        end
    end

    task automatic wait_valids(input int n, input int bound);
        int start = valid_cnt;
        int c = 0;
        while (valid_cnt < start + n && c < bound) begin
            @(negedge Clk);
            #1;
            c++;
        end
        chk("valid_count", 32'(valid_cnt - start), 32'(n));
    endtask

    task automatic convert(input logic [7:0] b, input logic [11:0] eb, input logic ee);
        int lat = 0;
        @(negedge Clk);
        Bin = b;
        q.push_back({eb, ee});
        do begin
            @(posedge Clk);
            #1;
            lat++;
        end while (Valid !== 1'b1 && lat < 40);
        chk("latency", 32'(lat), 32'd10);
        @(posedge Clk);
        #1;
        chk("valid_width", 32'(Valid), 32'd0);
    endtask

    task automatic check_display(input logic [11:0] eb, input logic tc);
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        logic [6:0] es;
        logic       ed;
        logic       ok;
        repeat (2) @(posedge Clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            ok = 1'b1;
            es = 7'b1111111;
            ed = 1'b1;
            case (An)
                3'b110: begin
                    c0++;
                    es = seg7(eb[3:0]);
                    ed = !tc;
                end
                3'b101: begin
                    c1++;
                    es = (eb[11:8] == 4'd0 && eb[7:4] == 4'd0) ? 7'b1111111 : seg7(eb[7:4]);
                end
                3'b011: begin
                    c2++;
                    es = (eb[11:8] == 4'd0) ? 7'b1111111 : seg7(eb[11:8]);
                end
                default: begin
                    ok = 1'b0;
                    chk("an_onehot", 32'(An), 32'b110);
                end
            endcase
            if (ok) begin
                chk("seg", 32'(Seg), 32'(es));
                chk("dp", 32'(Dp), 32'(ed));
            end
        end
        chk("slot_units", 32'(c0), 32'd4);
        chk("slot_tens", 32'(c1), 32'd4);
        chk("slot_hundreds", 32'(c2), 32'd4);
    endtask

    initial begin
        int lat;
        // Reset state
        #1 MR = 1'b0;
        #20;
        chk("rst_bcd", 32'(Bcd), 32'd0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_seg", 32'(Seg), 32'h7f);
        chk("rst_an", 32'(An), 32'b111);
        chk("rst_dp", 32'(Dp), 32'd1);

        // Release with Bin = 0: forced capture at first edge
        @(negedge Clk);
        q.push_back({12'h000, 1'b0});
        MR = 1'b1;
        lat = 0;
        do begin
            @(posedge Clk);
            #1;
            lat++;
            if (lat == 1) begin
                chk("first_an", 32'(An), 32'b110);
                chk("first_seg", 32'(Seg), 32'b1000000);
            end
        end while (Valid !== 1'b1 && lat < 40);
        chk("rst_latency", 32'(lat), 32'd10);
        check_display(12'h000, 1'b0);

        // Main conversions
        convert(8'd119, 12'h119, 1'b0);
        check_display(12'h119, 1'b0);
        convert(8'd7, 12'h007, 1'b0);
        check_display(12'h007, 1'b0);
        convert(8'd200, 12'h200, 1'b1);
        check_display(12'h200, 1'b0);
        convert(8'd5, 12'h005, 1'b0);
        convert(8'd255, 12'h255, 1'b1);
        convert(8'd99, 12'h099, 1'b0);
        check_display(12'h099, 1'b0);

        // Bin changes during conversion: only 10 and the final 12
        @(negedge Clk);
        Bin = 8'd10;
        q.push_back({12'h010, 1'b0});
        @(posedge Clk);
        @(negedge Clk);
        Bin = 8'd11;
        @(negedge Clk);
        Bin = 8'd12;
        q.push_back({12'h012, 1'b0});
        wait_valids(2, 60);
        repeat (20) @(posedge Clk);
        chk("toggle_queue_empty", 32'(q.size()), 32'd0);

        // Decimal point on units slot only
        @(negedge Clk);
        TCin = 1'b1;
        check_display(12'h012, 1'b1);

        // Reset mid-conversion
        @(negedge Clk);
        Bin = 8'd50;
        q.push_back({12'h050, 1'b0});
        repeat (3) @(posedge Clk);
        #2 MR = 1'b0;
        #1;
        chk("mr_bcd", 32'(Bcd), 32'd0);
        chk("mr_valid", 32'(Valid), 32'd0);
        chk("mr_seg", 32'(Seg), 32'h7f);
        chk("mr_an", 32'(An), 32'b111);
        chk("mr_dp", 32'(Dp), 32'd1);
        repeat (2) @(negedge Clk);
        chk("mr_hold_valid", 32'(Valid), 32'd0);
        MR = 1'b1;
        wait_valids(1, 40);
        repeat (20) @(posedge Clk);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
